// File: rtl/sevenseg_pkg.sv
// Shared 7-segment definitions: active-low glyph table (g..a) and reverse lookup.
// Used by both the encoder and the scan decoder.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h27, 7'h33, 7'h1D, 7'h16, 7'h07, 7'h7F
  };

  // Returns {legal, nibble}; all-off (blank) decodes to F.
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg_n);
    logic [4:0] res;
    res = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (seg_n == GLYPH[i]) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational active-low 7-segment pattern to {legal, nibble} decoder.
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       legal,
  output logic [3:0] nibble
);

  assign {legal, nibble} = seg_to_nibble(seg_n);

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Reads back a multiplexed active-low 7-segment bus: captures each digit once its
// pattern has been stable long enough, decodes it and reports frames and bad glyphs.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_ok,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic [2:0]              err_digit
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [6:0]              s_seg_q;
  logic [NUM_DIGITS-1:0]   s_en_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    captured_q, captured_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_upd;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   ok_q, ok_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;
  logic [2:0]              err_digit_q, err_digit_d;

  logic       in_legal, s_legal, restart, capture;
  logic       glyph_legal;
  logic [3:0] glyph_nibble;
  logic [2:0] s_idx;

  sevenseg_glyph_decode u_glyph_decode (
    .seg_n  (s_seg_q),
    .legal  (glyph_legal),
    .nibble (glyph_nibble)
  );

  assign in_legal = $onehot(~dig_en_n);
  assign s_legal  = $onehot(~s_en_q);
  // A new sample that differs, or any blank/ghost select, starts a fresh dwell.
  assign restart  = (seg_n != s_seg_q) || (dig_en_n != s_en_q) || !in_legal;
  assign capture  = s_legal && (cnt_q == CntMax) && !captured_q;

  always_comb begin
    s_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!s_en_q[k]) s_idx = 3'(k);
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    captured_d  = captured_q;
    seen_d      = seen_q;
    seen_upd    = seen_q;
    val_d       = val_q;
    ok_d        = ok_q;
    frame_d     = 1'b0;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;

    if (capture) captured_d = 1'b1;
    if (restart) begin
      cnt_d      = in_legal ? CntW'(1) : '0;
      captured_d = 1'b0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (capture) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (s_idx == 3'(k)) begin
          seen_upd[k] = 1'b1;
          ok_d[k]     = glyph_legal;
          if (glyph_legal) val_d[4*k +: 4] = glyph_nibble;
        end
      end
      if (!glyph_legal) begin
        err_d       = 1'b1;
        err_digit_d = s_idx;
      end
      if (&seen_upd) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg_q     <= SEG_BLANK;
      s_en_q      <= '1;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      seen_q      <= '0;
      val_q       <= '0;
      ok_q        <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      s_seg_q     <= seg_n;
      s_en_q      <= dig_en_n;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      seen_q      <= seen_d;
      val_q       <= val_d;
      ok_q        <= ok_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign digit_val   = val_q;
  assign digit_ok    = ok_q;
  assign frame_valid = frame_q;
  assign pattern_err = err_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus random dwells, all checked
// against a history-based model of the stable-pattern capture rules.
module tb_sevenseg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_en_n;
  logic [4*ND-1:0] digit_val;
  logic [ND-1:0] digit_ok;
  logic          frame_valid, pattern_err;
  logic [2:0]    err_digit;

  sevenseg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_en_n    (dig_en_n),
    .digit_val   (digit_val),
    .digit_ok    (digit_ok),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h18; 10: return 7'h27; 11: return 7'h33;
      12: return 7'h1D; 13: return 7'h16; 14: return 7'h07; default: return 7'h7F;
    endcase
  endfunction

  // Reference model: keep recent samples; a capture is due when the trailing run of
  // identical, singly-selected samples first reaches SC, and lands one edge later.
  logic [4*ND-1:0] m_val = '0;
  logic [ND-1:0]   m_ok = '0, m_seen = '0;
  logic            m_frame = 1'b0, m_err = 1'b0;
  logic [2:0]      m_err_digit = '0;
  logic            pend = 1'b0;
  logic [6+ND:0]   pend_s;
  logic [6+ND:0]   hist [$];

  always @(posedge clk) begin
    logic [6+ND:0] cur;
    int run, k, nib;
    m_frame = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_val = '0; m_ok = '0; m_seen = '0; m_err_digit = '0; pend = 1'b0;
      hist.delete();
    end else begin
      if (pend) begin
        k = 0;
        for (int j = 0; j < ND; j++) if (!pend_s[j]) k = j;
        nib = -1;
        for (int n = 0; n < 16; n++) if (glyph(n) == pend_s[6+ND:ND]) nib = n;
        if (nib >= 0) begin
          m_val[4*k +: 4] = 4'(nib);
          m_ok[k] = 1'b1;
        end else begin
          m_ok[k] = 1'b0; m_err = 1'b1; m_err_digit = 3'(k);
        end
        m_seen[k] = 1'b1;
        if (m_seen == '1) begin
          m_frame = 1'b1; m_seen = '0;
        end
      end
      cur = {seg_n, dig_en_n};
      hist.push_back(cur);
      if (hist.size() > SC + 1) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != cur) break;
        run++;
      end
      pend   = ($countones(~dig_en_n) == 1) && (run == SC);
      pend_s = cur;
    end
  end

  int total = 0, bad = 0;
  int n_frame, n_err, n_mis;

  // Drive inputs and advance n cycles, tallying pulses and model disagreements.
  task automatic hold(input logic [6:0] s, input logic [ND-1:0] e, input int n);
    seg_n = s;
    dig_en_n = e;
    repeat (n) begin
      @(negedge clk);
      if (frame_valid) n_frame++;
      if (pattern_err) n_err++;
      if ({digit_val, digit_ok, frame_valid, pattern_err, err_digit} !==
          {m_val, m_ok, m_frame, m_err, m_err_digit}) begin
        n_mis++;
        if (n_mis <= 4)
          $display("model diff t=%0t dut val=%h ok=%b fv=%b pe=%b ed=%0d model val=%h ok=%b fv=%b pe=%b ed=%0d",
                   $time, digit_val, digit_ok, frame_valid, pattern_err, err_digit,
                   m_val, m_ok, m_frame, m_err, m_err_digit);
      end
    end
  endtask

  task automatic clear_tallies();
    n_frame = 0; n_err = 0; n_mis = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold(7'h7F, '1, 2);
    rst = 1'b0;
  endtask

  function automatic logic [ND-1:0] sel(input int d);
    return ND'(~(ND'(1) << d));
  endfunction

  task automatic test_reset();
    clear_tallies();
    do_reset();
    hold(7'h7F, '1, 1);
    total++; if (digit_val !== '0) begin bad++; $display("FAIL reset_val got=%h want=0", digit_val); end
    total++; if (digit_ok !== '0) begin bad++; $display("FAIL reset_ok got=%b want=0", digit_ok); end
    total++; if (frame_valid !== 1'b0 || pattern_err !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b want=00", frame_valid, pattern_err);
    end
    total++; if (err_digit !== '0) begin bad++; $display("FAIL reset_errdig got=%0d want=0", err_digit); end
  endtask

  task automatic test_loopback();
    clear_tallies();
    for (int n = 0; n < 16; n++) begin
      hold(glyph(n), 4'b1110, 6);
      total++; if (digit_val[3:0] !== 4'(n) || digit_ok[0] !== 1'b1) begin
        bad++; $display("FAIL loopback_%0d got=%h/%b want=%h/1", n, digit_val[3:0], digit_ok[0], n);
      end
    end
    total++; if (n_err !== 0 || n_mis !== 0) begin
      bad++; $display("FAIL loopback_clean got err=%0d diff=%0d want 0/0", n_err, n_mis);
    end
  endtask

  task automatic test_latency();
    clear_tallies();
    rst = 1'b1;
    hold(7'h30, 4'b1110, 1);
    rst = 1'b0;
    for (int e = 1; e <= SC; e++) begin
      hold(7'h30, 4'b1110, 1);
      total++; if (digit_val[3:0] !== 4'h0) begin
        bad++; $display("FAIL latency_early_e%0d got=%h want=0", e, digit_val[3:0]);
      end
    end
    hold(7'h30, 4'b1110, 1);
    total++; if (digit_val[3:0] !== 4'h3) begin
      bad++; $display("FAIL latency_edge got=%h want=3", digit_val[3:0]);
    end
    hold(7'h30, 4'b1110, 20);
    total++; if (n_err !== 0 || n_frame !== 0 || n_mis !== 0 || digit_val[3:0] !== 4'h3) begin
      bad++; $display("FAIL latency_hold got err=%0d fr=%0d diff=%0d val=%h want 0/0/0/3",
                      n_err, n_frame, n_mis, digit_val[3:0]);
    end
  endtask

  task automatic test_full_scan();
    clear_tallies();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      n_frame = 0;
      for (int d = 0; d < ND; d++) hold(glyph(d + 1), sel(d), 5);
      total++; if (frame_valid !== 1'b1 || digit_val[15:12] !== 4'h4) begin
        bad++; $display("FAIL scan_coincident_p%0d got fv=%b d3=%h want 1/4", pass, frame_valid, digit_val[15:12]);
      end
      total++; if (digit_val !== 16'h4321 || n_frame !== 1) begin
        bad++; $display("FAIL scan_p%0d got val=%h frames=%0d want 4321/1", pass, digit_val, n_frame);
      end
    end
    hold(7'h7F, '1, 1);
    total++; if (frame_valid !== 1'b0 || n_mis !== 0) begin
      bad++; $display("FAIL scan_pulse_width got fv=%b diff=%0d want 0/0", frame_valid, n_mis);
    end
  endtask

  task automatic test_illegal();
    clear_tallies();
    do_reset();
    hold(glyph(9), sel(2), 5);
    hold(glyph(1), sel(0), 5);
    hold(glyph(2), sel(1), 5);
    hold(7'h7E, sel(2), 5);
    total++; if (pattern_err !== 1'b1 || err_digit !== 3'd2) begin
      bad++; $display("FAIL illegal_pulse got pe=%b ed=%0d want 1/2", pattern_err, err_digit);
    end
    total++; if (digit_ok[2] !== 1'b0 || digit_val[11:8] !== 4'h9) begin
      bad++; $display("FAIL illegal_hold got ok2=%b d2=%h want 0/9", digit_ok[2], digit_val[11:8]);
    end
    hold(glyph(7), sel(3), 5);
    total++; if (frame_valid !== 1'b1 || n_frame !== 1 || n_err !== 1 || err_digit !== 3'd2) begin
      bad++; $display("FAIL illegal_frame got fv=%b fr=%0d errs=%0d ed=%0d want 1/1/1/2",
                      frame_valid, n_frame, n_err, err_digit);
    end
    total++; if (n_mis !== 0) begin bad++; $display("FAIL illegal_model got diff=%0d want 0", n_mis); end
  endtask

  task automatic test_glitch_ghost();
    clear_tallies();
    do_reset();
    for (int d = 0; d < 3; d++) hold(glyph(d + 10), sel(d), 5);
    n_frame = 0; n_err = 0;
    for (int i = 0; i < 6; i++) hold(glyph(i), sel(3), 3);
    hold(glyph(8), 4'b1100, 10);
    hold(7'h7F, '1, 5);
    total++; if (n_frame !== 0 || n_err !== 0 || digit_val[15:12] !== 4'h0 || digit_ok[3] !== 1'b0) begin
      bad++; $display("FAIL glitch_nocap got fr=%0d errs=%0d d3=%h ok3=%b want 0/0/0/0",
                      n_frame, n_err, digit_val[15:12], digit_ok[3]);
    end
    hold(glyph(5), sel(3), 5);
    total++; if (frame_valid !== 1'b1 || digit_val !== 16'h5CBA) begin
      bad++; $display("FAIL glitch_seen got fv=%b val=%h want 1/5cba", frame_valid, digit_val);
    end
    total++; if (n_mis !== 0) begin bad++; $display("FAIL glitch_model got diff=%0d want 0", n_mis); end
  endtask

  task automatic test_reset_mid_frame();
    clear_tallies();
    do_reset();
    for (int d = 0; d < 3; d++) hold(glyph(d + 6), sel(d), 5);
    rst = 1'b1;
    hold(glyph(8), sel(2), 1);
    rst = 1'b0;
    total++; if (digit_val !== '0 || digit_ok !== '0 || frame_valid !== 1'b0 || pattern_err !== 1'b0) begin
      bad++; $display("FAIL midreset_clear got val=%h ok=%b fv=%b pe=%b want 0", digit_val, digit_ok,
                      frame_valid, pattern_err);
    end
    n_frame = 0;
    hold(glyph(4), sel(3), 5);
    total++; if (n_frame !== 0 || digit_val[15:12] !== 4'h4) begin
      bad++; $display("FAIL midreset_partial got fr=%0d d3=%h want 0/4", n_frame, digit_val[15:12]);
    end
    for (int d = 0; d < ND; d++) hold(glyph(d), sel(d), 5);
    total++; if (n_frame !== 1 || n_mis !== 0) begin
      bad++; $display("FAIL midreset_rescan got fr=%0d diff=%0d want 1/0", n_frame, n_mis);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [ND-1:0] e;
    int r;
    clear_tallies();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) e = sel($urandom_range(0, ND - 1));
      else if (r == 8) e = '1;
      else e = ND'($urandom);
      s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph($urandom_range(0, 15));
      hold(s, e, $urandom_range(1, 7));
    end
    total++; if (n_mis !== 0) begin bad++; $display("FAIL random_model got diff=%0d want 0", n_mis); end
  endtask

  initial begin
    rst = 1'b1;
    seg_n = 7'h7F;
    dig_en_n = '1;
    test_reset();
    test_loopback();
    test_latency();
    test_full_scan();
    test_illegal();
    test_glitch_ghost();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
